// File: rtl/csel_pkg.sv
// Shared defaults and the candidate-result record for the carry-select subtractor.
package csel_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam int SPLIT_DEFAULT = 16;
    localparam int MAX_WIDTH     = 64;

    // Sized for the widest legal operand; narrower uses zero-extend into diff.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] diff;
        logic                 borrow;
    } sub_result_t;
endpackage

// File: rtl/ripple_borrow_subtractor.sv
// Plain ripple-borrow subtractor: D = A - B - Bin, Bout set when A < B + Bin.
module ripple_borrow_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);
    logic [WIDTH:0] borrow_chain;

    assign borrow_chain[0] = Bin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign D[gi]              = A[gi] ^ B[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~A[gi] & B[gi]) | (~(A[gi] ^ B[gi]) & borrow_chain[gi]);
        end
    endgenerate

    assign Bout = borrow_chain[WIDTH];
endmodule

// File: rtl/pipelined_csel_subtractor.sv
// Two-stage carry-select subtractor with valid/ready flow control on both sides.
// Stage 1 resolves the low block and both upper candidates; stage 2 selects and flags.
module pipelined_csel_subtractor
    import csel_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SPLIT = SPLIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);
    localparam int UW = WIDTH - SPLIT;

    logic [SPLIT-1:0] lo_d;
    logic             lo_b;
    logic [UW-1:0]    hi0_d;
    logic             hi0_b;
    logic [UW-1:0]    hi1_d;
    logic             hi1_b;

    // Borrow-in enters the low chain directly; the upper block is computed both ways.
    ripple_borrow_subtractor #(.WIDTH(SPLIT)) u_lo (
        .A    (A[SPLIT-1:0]),
        .B    (B[SPLIT-1:0]),
        .Bin  (Bin),
        .D    (lo_d),
        .Bout (lo_b)
    );

    ripple_borrow_subtractor #(.WIDTH(UW)) u_hi0 (
        .A    (A[WIDTH-1:SPLIT]),
        .B    (B[WIDTH-1:SPLIT]),
        .Bin  (1'b0),
        .D    (hi0_d),
        .Bout (hi0_b)
    );

    ripple_borrow_subtractor #(.WIDTH(UW)) u_hi1 (
        .A    (A[WIDTH-1:SPLIT]),
        .B    (B[WIDTH-1:SPLIT]),
        .Bin  (1'b1),
        .D    (hi1_d),
        .Bout (hi1_b)
    );

    logic             s1_valid_reg;
    logic             s2_valid_reg;
    logic [SPLIT-1:0] s1_lo_d_reg;
    logic             s1_lo_b_reg;
    logic [UW-1:0]    s1_hi0_d_reg;
    logic             s1_hi0_b_reg;
    logic [UW-1:0]    s1_hi1_d_reg;
    logic             s1_hi1_b_reg;
    logic             s1_a_sign_reg;
    logic             s1_b_sign_reg;

    logic s2_load;
    logic in_fire;
    logic s2_fire;

    // Stage 2 accepts when empty or draining this cycle; stage 1 follows the same rule.
    assign s2_load   = !s2_valid_reg || out_ready;
    assign in_ready  = !s1_valid_reg || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign s2_fire   = s2_load && s1_valid_reg;
    assign out_valid = s2_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_lo_d_reg   <= lo_d;
            s1_lo_b_reg   <= lo_b;
            s1_hi0_d_reg  <= hi0_d;
            s1_hi0_b_reg  <= hi0_b;
            s1_hi1_d_reg  <= hi1_d;
            s1_hi1_b_reg  <= hi1_b;
            s1_a_sign_reg <= A[WIDTH-1];
            s1_b_sign_reg <= B[WIDTH-1];
        end
    end

    sub_result_t      sel_hi;
    logic [WIDTH-1:0] d_next;
    logic             v_next;
    logic             z_next;

    always_comb begin
        sel_hi        = '0;
        sel_hi.diff   = {{(MAX_WIDTH-UW){1'b0}}, (s1_lo_b_reg ? s1_hi1_d_reg : s1_hi0_d_reg)};
        sel_hi.borrow = s1_lo_b_reg ? s1_hi1_b_reg : s1_hi0_b_reg;
    end

    // The zero-extended upper field keeps the Z reduction honest across the whole record.
    assign d_next = {sel_hi.diff[UW-1:0], s1_lo_d_reg};
    assign v_next = (s1_a_sign_reg != s1_b_sign_reg) && (sel_hi.diff[UW-1] != s1_a_sign_reg);
    assign z_next = (sel_hi.diff == '0) && (s1_lo_d_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D    <= '0;
            Bout <= 1'b0;
            V    <= 1'b0;
            Z    <= 1'b0;
        end else if (s2_fire) begin
            D    <= d_next;
            Bout <= sel_hi.borrow;
            V    <= v_next;
            Z    <= z_next;
        end
    end
endmodule

// File: tb/tb_pipelined_csel_subtractor.sv
// Directed-vector and scenario bench for pipelined_csel_subtractor at WIDTH=32, SPLIT=16.
module tb_pipelined_csel_subtractor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    int checks   = 0;
    int failures = 0;

    pipelined_csel_subtractor #(.WIDTH(32), .SPLIT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] b, input logic bin,
                           input logic [31:0] d, input logic bout, input logic v, input logic z);
        vec_t t;
        t.name = n; t.a = a; t.b = b; t.bin = bin;
        t.d = d; t.bout = bout; t.v = v; t.z = z;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: wide unsigned subtraction, overflow from operand/result signs.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] full;
        logic [31:0] d;
        full = {1'b0, a} - {1'b0, b} - {32'b0, bin};
        d    = full[31:0];
        return {d, full[32], (a[31] != b[31]) && (d[31] != a[31]), d == 32'h0};
    endfunction

    function automatic logic [34:0] cur_out();
        return {D, Bout, V, Z};
    endfunction

    logic [31:0] bp_a [4];
    logic [31:0] bp_b [4];
    logic        bp_bin [4];
    logic [34:0] bp_exp [4];
    logic [34:0] q[$];
    logic [34:0] prev_out;
    logic        prev_hold;
    logic        stale;
    int          lat;
    int          idx;
    int          got;
    int          cyc;
    int          sent;
    localparam int NR = 10000;

    initial begin
        add_vec("underflow",    32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        add_vec("signed_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        add_vec("split_bin",    32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        add_vec("zero_eq",      32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        add_vec("small",        32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        add_vec("small_neg",    32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        add_vec("ovf_neg_b",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        add_vec("ones_bin",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        add_vec("bin_to_zero",  32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        add_vec("zero_bin",     32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        add_vec("split_borrow", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        add_vec("min_min",      32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        add_vec("mixed",        32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0);
        add_vec("pos_minus_neg",32'h1234_5678, 32'h8765_4321, 1'b0, 32'h8ACF_1357, 1'b1, 1'b1, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_state", {out_valid, in_ready, D, Bout, V, Z}, {1'b0, 1'b1, 35'h0});
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time, with latency measured in cycles.
        foreach (vecs[i]) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            A = vecs[i].a; B = vecs[i].b; Bin = vecs[i].bin;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            $display("txn %s A=%h B=%h Bin=%0d -> D=%h Bout=%0d V=%0d Z=%0d lat=%0d",
                     vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].bin, D, Bout, V, Z, lat);
            check({vecs[i].name, "_latency"}, lat, 2);
            check({vecs[i].name, "_result"}, cur_out(),
                  {vecs[i].d, vecs[i].bout, vecs[i].v, vecs[i].z});
        end

        // Backpressure: four back-to-back operands against a stalled consumer.
        for (int k = 0; k < 4; k++) begin
            bp_a[k]   = 32'h1000_0000 * (k + 1) + 32'h0000_8000;
            bp_b[k]   = 32'h0000_9000 + k;
            bp_bin[k] = k[0];
            bp_exp[k] = model(bp_a[k], bp_b[k], bp_bin[k]);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; A = bp_a[k]; B = bp_b[k]; Bin = bp_bin[k];
            #1 check("bp_accept_ready", in_ready, 1);
            @(negedge clk);
        end
        A = bp_a[2]; B = bp_b[2]; Bin = bp_bin[2];
        #1 check("bp_full_in_ready", in_ready, 0);
        check("bp_head", {out_valid, cur_out()}, {1'b1, bp_exp[0]});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check("bp_hold", {in_ready, out_valid, cur_out()}, {1'b0, 1'b1, bp_exp[0]});
            $display("txn bp_stall cycle=%0d D=%h in_ready=%0d", k, D, in_ready);
        end
        idx = 2; got = 0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            in_valid  = (idx < 4);
            if (idx < 4) begin
                A = bp_a[idx]; B = bp_b[idx]; Bin = bp_bin[idx];
            end
            #1 check("bp_no_gap", out_valid, 1);
            if (out_valid) begin
                $display("txn bp_drain n=%0d D=%h Bout=%0d V=%0d Z=%0d", got, D, Bout, V, Z);
                check("bp_order", cur_out(), bp_exp[got]);
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        check("bp_count", got, 4);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("bp_empty_after", out_valid, 0);

        // Mid-stream reset with two results in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        A = 32'hDEAD_BEEF; B = 32'h0000_0001; Bin = 1'b0;
        @(negedge clk);
        A = 32'hCAFE_0000; B = 32'h0000_0002; Bin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("rst_pre_full", {out_valid, in_ready}, 2'b10);
        #1 rst_n = 1'b0;
        #1 check("rst_mid", {out_valid, in_ready, D, Bout, V, Z}, {1'b0, 1'b1, 35'h0});
        $display("txn mid_reset out_valid=%0d in_ready=%0d", out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 stale = stale | out_valid;
        end
        check("rst_no_stale", stale, 0);
        @(negedge clk);
        in_valid = 1'b1; A = 32'h0000_0100; B = 32'h0000_0101; Bin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        $display("txn post_reset_first D=%h Bout=%0d lat=%0d", D, Bout, lat);
        check("rst_first_latency", lat, 2);
        check("rst_first_result", cur_out(), model(32'h0000_0100, 32'h0000_0101, 1'b1));

        // Random operands with random stalls on both sides against the model.
        sent = 0; cyc = 0; prev_hold = 1'b0; prev_out = '0;
        while ((sent < NR || q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < NR) && ($urandom_range(0, 3) != 0);
            A   = $urandom;
            B   = $urandom;
            Bin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: B = A;
                1: A = {A[31:16], 16'h0000};
                2: B = {16'h0000, B[15:0]};
                default: ;
            endcase
            #1;
            if (prev_hold) check("rand_hold_stable", {out_valid, cur_out()}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rand_spurious_valid", out_valid, 0);
                else               check("rand_result", cur_out(), q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, Bin));
                sent++;
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = cur_out();
        end
        in_valid = 1'b0;
        check("rand_drained", q.size() + (NR - sent), 0);
        $display("txn random sent=%0d cycles=%0d", sent, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
